// File: rtl/dlx_decode.sv
// DLX instruction decode stage with a 32x32 register file and a pending-write scoreboard.
// Decodes one instruction per accept into a registered ALU bundle held under backpressure.
// Ports:
//   clk_i, rst_i                     clock; synchronous active-high reset
//   if_valid_i, if_instr_i, if_pc_i  fetched instruction
//   id_ready_o                       decode can accept this cycle (combinational)
//   wb_en_i, wb_rd_i, wb_data_i      register-file write port
//   ex_ready_i                       ALU consumes the bundle this cycle
//   ex_*_o                           registered bundle: valid, ALU op, operands, rd/we,
//                                    load/store flags, store data, PC, illegal flag
module dlx_decode #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        id_ready_o,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_rd_i,
    input  logic [31:0] wb_data_i,
    input  logic        ex_ready_i,
    output logic        ex_valid_o,
    output logic [3:0]  ex_I_o,
    output logic [31:0] ex_op1_o,
    output logic [31:0] ex_op2_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_we_o,
    output logic        ex_load_o,
    output logic        ex_store_o,
    output logic [31:0] ex_sdata_o,
    output logic [31:0] ex_pc_o,
    output logic        ex_illegal_o
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        load;
        logic        store;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic        illegal;
    } bundle_t;

    logic [31:0] regs_q [32];
    logic [31:0] pend_q, pend_d;
    bundle_t     bundle_q, bundle_d, dec_bundle;

    logic [5:0]  opcode, func;
    logic [4:0]  f_rs1, f_rs2, f_rt, f_rd, dest;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        rtype, use_rs1, use_rs2, use_rd_src, writes;
    logic        is_lhi, is_load, is_store, illegal, imm_zext, we;
    logic [31:0] wb_hit, busy_mask, need_mask;
    logic [31:0] rs1_val, rs2_val, rt_val;
    logic        hazard, accept;

    assign opcode = if_instr_i[31:26];
    assign f_rs1  = if_instr_i[25:21];
    assign f_rs2  = if_instr_i[20:16];
    assign f_rt   = if_instr_i[20:16];
    assign f_rd   = if_instr_i[15:11];
    assign func   = if_instr_i[5:0];
    assign imm    = if_instr_i[15:0];

    always_comb begin
        alu_op     = 4'd0;
        rtype      = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd_src = 1'b0;
        writes     = 1'b0;
        is_lhi     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        illegal    = 1'b0;
        imm_zext   = 1'b0;
        if (opcode == 6'h00) begin
            rtype   = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            writes  = 1'b1;
            case (func)
                6'h20: alu_op = 4'd0;
                6'h22: alu_op = 4'd1;
                6'h24: alu_op = 4'd2;
                6'h25: alu_op = 4'd3;
                6'h26: alu_op = 4'd4;
                6'h04: alu_op = 4'd5;
                6'h06: alu_op = 4'd6;
                6'h07: alu_op = 4'd7;
                // 0x28..0x2D map directly onto SEQ..SGE (8..13)
                6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D: alu_op = func[3:0];
                default: begin
                    illegal = 1'b1;
                    use_rs1 = 1'b0;
                    use_rs2 = 1'b0;
                    writes  = 1'b0;
                end
            endcase
        end else begin
            use_rs1 = 1'b1;
            writes  = 1'b1;
            case (opcode)
                6'h08: alu_op = 4'd0;
                6'h0A: alu_op = 4'd1;
                6'h0C: begin alu_op = 4'd2; imm_zext = 1'b1; end
                6'h0D: begin alu_op = 4'd3; imm_zext = 1'b1; end
                6'h0E: begin alu_op = 4'd4; imm_zext = 1'b1; end
                6'h14: alu_op = 4'd5;
                6'h16: alu_op = 4'd6;
                6'h17: alu_op = 4'd7;
                6'h18, 6'h19, 6'h1A, 6'h1B, 6'h1C, 6'h1D: alu_op = opcode[3:0];
                6'h0F: begin is_lhi = 1'b1; use_rs1 = 1'b0; end
                6'h23: is_load = 1'b1;
                6'h2B: begin is_store = 1'b1; writes = 1'b0; use_rd_src = 1'b1; end
                default: begin
                    illegal = 1'b1;
                    use_rs1 = 1'b0;
                    writes  = 1'b0;
                end
            endcase
        end
    end

    assign dest = rtype ? f_rd : f_rt;
    assign we   = writes && (dest != 5'd0);

    // A register being written this cycle is treated as already available.
    assign wb_hit    = (WB_BYPASS && wb_en_i) ? (32'd1 << wb_rd_i) : 32'd0;
    assign busy_mask = pend_q & ~wb_hit & ~32'd1;

    assign rs1_val = (f_rs1 == 5'd0) ? 32'd0 : wb_hit[f_rs1] ? wb_data_i : regs_q[f_rs1];
    assign rs2_val = (f_rs2 == 5'd0) ? 32'd0 : wb_hit[f_rs2] ? wb_data_i : regs_q[f_rs2];
    assign rt_val  = (f_rt  == 5'd0) ? 32'd0 : wb_hit[f_rt]  ? wb_data_i : regs_q[f_rt];

    assign need_mask = (use_rs1    ? (32'd1 << f_rs1) : 32'd0)
                     | (use_rs2    ? (32'd1 << f_rs2) : 32'd0)
                     | (use_rd_src ? (32'd1 << f_rt)  : 32'd0)
                     | (we         ? (32'd1 << dest)  : 32'd0);
    assign hazard    = |(need_mask & busy_mask);

    assign id_ready_o = !hazard && (!bundle_q.valid || ex_ready_i);
    assign accept     = if_valid_i && id_ready_o;

    always_comb begin
        dec_bundle         = '0;
        dec_bundle.valid   = 1'b1;
        dec_bundle.pc      = if_pc_i;
        dec_bundle.illegal = illegal;
        if (!illegal) begin
            dec_bundle.alu   = alu_op;
            dec_bundle.op1   = is_lhi ? 32'd0 : rs1_val;
            dec_bundle.rd    = writes ? dest : 5'd0;
            dec_bundle.we    = we;
            dec_bundle.load  = is_load;
            dec_bundle.store = is_store;
            dec_bundle.sdata = is_store ? rt_val : 32'd0;
            if (rtype)         dec_bundle.op2 = rs2_val;
            else if (is_lhi)   dec_bundle.op2 = {imm, 16'h0000};
            else if (imm_zext) dec_bundle.op2 = {16'h0000, imm};
            else               dec_bundle.op2 = {{16{imm[15]}}, imm};
        end
    end

    always_comb begin
        bundle_d = bundle_q;
        if (accept) begin
            bundle_d = dec_bundle;
        end else if (ex_ready_i) begin
            bundle_d.valid = 1'b0;
        end
        pend_d = pend_q;
        if (wb_en_i) pend_d[wb_rd_i] = 1'b0;
        // Set after clear so a same-cycle set/clear of one bit stays pending.
        if (accept && we) pend_d[dest] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bundle_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            bundle_q <= bundle_d;
            pend_q   <= pend_d;
            if (wb_en_i && (wb_rd_i != 5'd0)) regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    assign ex_valid_o   = bundle_q.valid;
    assign ex_I_o       = bundle_q.alu;
    assign ex_op1_o     = bundle_q.op1;
    assign ex_op2_o     = bundle_q.op2;
    assign ex_rd_o      = bundle_q.rd;
    assign ex_we_o      = bundle_q.we;
    assign ex_load_o    = bundle_q.load;
    assign ex_store_o   = bundle_q.store;
    assign ex_sdata_o   = bundle_q.sdata;
    assign ex_pc_o      = bundle_q.pc;
    assign ex_illegal_o = bundle_q.illegal;

endmodule

// File: tb/tb_dlx_decode.sv
// Self-checking bench for dlx_decode: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of decode,
// register file, scoreboard and output handshake.
module tb_dlx_decode;

    logic        clk = 1'b0;
    logic        rst, if_valid, wb_en, ex_ready;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        id_ready, ex_valid, ex_we, ex_load, ex_store, ex_illegal;
    logic [3:0]  ex_I;
    logic [31:0] ex_op1, ex_op2, ex_sdata, ex_pc;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    dlx_decode #(.WB_BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_instr_i(if_instr),
        .if_pc_i(if_pc), .id_ready_o(id_ready), .wb_en_i(wb_en), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .ex_ready_i(ex_ready), .ex_valid_o(ex_valid), .ex_I_o(ex_I),
        .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_rd_o(ex_rd), .ex_we_o(ex_we),
        .ex_load_o(ex_load), .ex_store_o(ex_store), .ex_sdata_o(ex_sdata), .ex_pc_o(ex_pc),
        .ex_illegal_o(ex_illegal)
    );

    typedef struct packed {
        bit        v;
        bit [3:0]  alu;
        bit [31:0] op1, op2;
        bit [4:0]  rd;
        bit        we, ld, st;
        bit [31:0] sd, pc;
        bit        ill;
    } bun_t;

    // Opcode tables listed in ALU-op order, so the list index is the expected ex_I.
    int rlist [14] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h04, 'h06, 'h07,
                       'h28, 'h29, 'h2A, 'h2B, 'h2C, 'h2D};
    int ilist [14] = '{'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h14, 'h16, 'h17,
                       'h18, 'h19, 'h1A, 'h1B, 'h1C, 'h1D};
    int rmap [int];
    int imap [int];

    bit [31:0] m_regs [32];
    bit [31:0] m_pend;
    bun_t      m_b, m_dec;
    bit        m_zero, m_acc;
    bit [31:0] m_need;
    int        total = 0;
    int        bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] val(input int r);
        if (r == 0) return 32'd0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic void mdecode(input bit [31:0] ins, input bit [31:0] pc,
                                    output bun_t b, output bit [31:0] need);
        int op, fn, rs1, rs2, rdr, rdi;
        bit [15:0] imm;
        bit [31:0] sext;
        op = int'(ins[31:26]);  fn  = int'(ins[5:0]);
        rs1 = int'(ins[25:21]); rs2 = int'(ins[20:16]);
        rdr = int'(ins[15:11]); rdi = int'(ins[20:16]);
        imm = ins[15:0];
        sext = {{16{imm[15]}}, imm};
        b = '0; b.v = 1'b1; b.pc = pc; need = 32'd0;
        if (op == 0 && rmap.exists(fn)) begin
            b.alu = 4'(rmap[fn]); b.op1 = val(rs1); b.op2 = val(rs2);
            b.rd = 5'(rdr); b.we = (rdr != 0);
            need = (32'd1 << rs1) | (32'd1 << rs2) | (b.we ? (32'd1 << rdr) : 32'd0);
        end else if (op != 0 && imap.exists(op)) begin
            b.alu = 4'(imap[op]); b.op1 = val(rs1);
            b.op2 = (imap[op] >= 2 && imap[op] <= 4) ? {16'h0, imm} : sext;
            b.rd = 5'(rdi); b.we = (rdi != 0);
            need = (32'd1 << rs1) | (b.we ? (32'd1 << rdi) : 32'd0);
        end else if (op == 'h0F) begin
            b.op2 = {imm, 16'h0}; b.rd = 5'(rdi); b.we = (rdi != 0);
            need = b.we ? (32'd1 << rdi) : 32'd0;
        end else if (op == 'h23) begin
            b.op1 = val(rs1); b.op2 = sext; b.ld = 1'b1; b.rd = 5'(rdi); b.we = (rdi != 0);
            need = (32'd1 << rs1) | (b.we ? (32'd1 << rdi) : 32'd0);
        end else if (op == 'h2B) begin
            b.op1 = val(rs1); b.op2 = sext; b.st = 1'b1; b.sd = val(rdi);
            need = (32'd1 << rs1) | (32'd1 << rdi);
        end else begin
            b.ill = 1'b1;
        end
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit [31:0] busy;
        bit        rdy;
        @(negedge clk);
        mdecode(if_instr, if_pc, m_dec, m_need);
        busy = m_pend & ~32'd1;
        if (wb_en) busy[wb_rd] = 1'b0;
        rdy = ((m_need & busy) == 32'd0) && (!m_b.v || ex_ready);
        m_acc = if_valid && rdy;
        if (!rst) chk("id_ready", id_ready, rdy);
        chk("ex_valid", ex_valid, m_b.v);
        if (m_b.v || m_zero) begin
            chk("ex_I", ex_I, m_b.alu);         chk("ex_op1", ex_op1, m_b.op1);
            chk("ex_op2", ex_op2, m_b.op2);     chk("ex_rd", ex_rd, m_b.rd);
            chk("ex_we", ex_we, m_b.we);        chk("ex_load", ex_load, m_b.ld);
            chk("ex_store", ex_store, m_b.st);  chk("ex_sdata", ex_sdata, m_b.sd);
            chk("ex_pc", ex_pc, m_b.pc);        chk("ex_illegal", ex_illegal, m_b.ill);
        end
        @(posedge clk);
        if (rst) begin
            m_b = '0; m_zero = 1'b1; m_pend = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            if (wb_en) begin
                m_pend[wb_rd] = 1'b0;
                if (wb_rd != 0) m_regs[wb_rd] = wb_data;
            end
            if (m_acc) begin
                if (m_dec.we) m_pend[m_dec.rd] = 1'b1;
                m_b = m_dec; m_zero = 1'b0;
            end else if (ex_ready) begin
                m_b.v = 1'b0;
            end
        end
        #1;
    endtask

    function automatic bit [31:0] enc_r(input bit [4:0] rs1, input bit [4:0] rs2,
                                        input bit [4:0] rd, input bit [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'h00, fn};
    endfunction

    function automatic bit [31:0] enc_i(input bit [5:0] op, input bit [4:0] rs1,
                                        input bit [4:0] rd, input bit [15:0] imm);
        return {op, rs1, rd, imm};
    endfunction

    function automatic bit [31:0] rand_instr();
        bit [4:0] a, b, c;
        bit [15:0] imm;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
        c = 5'($urandom_range(0, 7)); imm = 16'($urandom);
        case ($urandom_range(0, 7))
            0, 1: begin
                if ($urandom_range(0, 5) == 0)
                    return enc_r(a, b, c, 6'($urandom_range(0, 63)));
                return enc_r(a, b, c, 6'(rlist[$urandom_range(0, 13)]));
            end
            2, 3: return enc_i(6'(ilist[$urandom_range(0, 13)]), a, b, imm);
            4: return enc_i(6'h0F, a, b, imm);
            5: return enc_i(6'h23, a, b, imm);
            6: return enc_i(6'h2B, a, b, imm);
            default: return enc_i(6'($urandom_range(0, 63)), a, b, imm);
        endcase
    endfunction

    initial begin
        foreach (rlist[i]) rmap[rlist[i]] = i;
        foreach (ilist[i]) imap[ilist[i]] = i;
        m_b = '0; m_zero = 1'b1; m_pend = '0;
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        #1 chk("post_reset_ready", id_ready, 1'b1);
        chk("post_reset_valid", ex_valid, 1'b0);

        // Register writes, then ADD r3,r1,r2
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd11; cycle();
        wb_rd = 5'd2; wb_data = 32'd2; cycle();
        wb_en = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100; if_instr = enc_r(5'd1, 5'd2, 5'd3, 6'h20); cycle();
        chk("add_valid", ex_valid, 1'b1); chk("add_I", ex_I, 4'd0);
        chk("add_op1", ex_op1, 32'd11);   chk("add_op2", ex_op2, 32'd2);
        chk("add_rd", ex_rd, 5'd3);       chk("add_we", ex_we, 1'b1);

        // SUB r6,r3,r1 stalls on r3 until its writeback is bypassed
        if_pc = 32'h104; if_instr = enc_r(5'd3, 5'd1, 5'd6, 6'h22);
        #1 chk("raw_stall", id_ready, 1'b0);
        repeat (2) cycle();
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd7;
        #1 chk("bypass_ready", id_ready, 1'b1);
        cycle();
        wb_en = 1'b0;
        chk("sub_I", ex_I, 4'd1); chk("sub_op1", ex_op1, 32'd7); chk("sub_op2", ex_op2, 32'd11);

        // ADDI sign-extends; held for 3 cycles of backpressure
        if_pc = 32'h108; if_instr = enc_i(6'h08, 5'd0, 5'd4, 16'hFFFF); cycle();
        chk("addi_op2", ex_op2, 32'hFFFF_FFFF);
        ex_ready = 1'b0; if_pc = 32'h10C; if_instr = enc_i(6'h0C, 5'd0, 5'd7, 16'hFFFF);
        repeat (3) begin
            #1 chk("bp_ready", id_ready, 1'b0);
            cycle();
            chk("bp_hold_op2", ex_op2, 32'hFFFF_FFFF); chk("bp_hold_pc", ex_pc, 32'h108);
        end
        ex_ready = 1'b1;
        #1 chk("bp_release", id_ready, 1'b1);
        cycle();
        chk("andi_op2", ex_op2, 32'h0000_FFFF); chk("andi_I", ex_I, 4'd2);
        if_pc = 32'h110; if_instr = enc_i(6'h0F, 5'd0, 5'd5, 16'h1234); cycle();
        chk("lhi_op1", ex_op1, 32'd0); chk("lhi_op2", ex_op2, 32'h1234_0000);

        // r0 stays zero; undefined opcode flagged illegal
        if_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd5; cycle();
        wb_en = 1'b0; if_valid = 1'b1;
        if_pc = 32'h114; if_instr = enc_r(5'd0, 5'd0, 5'd1, 6'h20); cycle();
        chk("r0_op1", ex_op1, 32'd0); chk("r0_op2", ex_op2, 32'd0);
        if_pc = 32'h118; if_instr = 32'hFC01_2345; cycle();
        chk("ill_flag", ex_illegal, 1'b1); chk("ill_we", ex_we, 1'b0);

        // Reset while stalled on pending r1
        if_pc = 32'h11C; if_instr = enc_r(5'd1, 5'd1, 5'd8, 6'h22);
        #1 chk("rst_pre_stall", id_ready, 1'b0);
        cycle();
        rst = 1'b1; cycle();
        rst = 1'b0;
        #1 chk("rst_valid", ex_valid, 1'b0); chk("rst_ready", id_ready, 1'b1);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            if_valid = ($urandom_range(0, 3) != 0);
            if_instr = rand_instr();
            if_pc    = $urandom;
            ex_ready = ($urandom_range(0, 3) != 0);
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_data  = $urandom;
            wb_rd    = 5'($urandom_range(0, 7));
            if (m_pend[7:1] != 0 && $urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    wb_rd = 5'($urandom_range(1, 7));
                    if (m_pend[wb_rd]) break;
                end
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlx_decode.md
DLX_DECODE -- requirements
Module: dlx_decode

Interface
REQ-001 Parameter: WB_BYPASS, 1, when 1 a same-cycle writeback to a source register supplies wb_data as the operand and clears the hazard that cycle.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  DLX instruction word.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 id_ready  out  1  decode accepts if_instr this cycle (combinational).
REQ-008 wb_en / wb_rd / wb_data  in  1/5/32  register-file write port.
REQ-009 ex_ready  in  1  ALU stage consumes the output bundle this cycle.
REQ-010 ex_valid  out  1  output bundle valid; drives the ALU EX enable.
REQ-011 ex_I  out  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SEQ, 9 SNE, 10 SLT, 11 SGT, 12 SLE, 13 SGE; 14-15 never emitted.
REQ-012 ex_op1 / ex_op2  out  32/32  ALU operands.
REQ-013 ex_rd / ex_we  out  5/1  destination register, write enable.
REQ-014 ex_load / ex_store / ex_sdata / ex_pc / ex_illegal  out  1/1/32/32/1  memory flags, store data, PC, illegal flag.

Function
REQ-015 Register file 32x32; r0 reads 0; writes to r0 ignored; wb_en write on rising edge.
REQ-016 Fields: op=[31:26], rs1=[25:21]; R-type (op 0x00): rs2=[20:16], rd=[15:11], func=[5:0]; I-type: rd=[20:16], imm=[15:0].
REQ-017 R-type func -> ex_I: 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, 04 SLL, 06 SRL, 07 SRA, 28-2D SEQ..SGE (hex); op1=R[rs1], op2=R[rs2].
REQ-018 I-type op -> ex_I: 08 ADDI, 0A SUBI, 0C ANDI, 0D ORI, 0E XORI, 14 SLLI, 16 SRLI, 17 SRAI, 18-1D SEQI..SGEI; op1=R[rs1], op2=imm.
REQ-019 imm zero-extended for ANDI/ORI/XORI; sign-extended for all others.
REQ-020 LHI (0F): ex_I=ADD, op1=0, op2={imm,16'h0}.
REQ-021 LW (23): ex_I=ADD, op1=R[rs1], op2=sext(imm), ex_load=1, ex_we=1. SW (2B): ex_I=ADD, ex_store=1, ex_sdata=R[rd field], ex_we=0.
REQ-022 Any other op/func: ex_illegal=1, ex_we=0, ex_load=0, ex_store=0, ex_I=0; still occupies one bundle.
REQ-023 ex_we=0 whenever destination is r0.
REQ-024 Scoreboard: 32-bit pending mask; bit rd set when a bundle with ex_we=1 is loaded; cleared on wb_en for that register; same-cycle set and clear of one bit resolves to set.
REQ-025 Hazard: stall when any used source (rs1, rs2 for R-type, rd for SW) or destination with we=1 is pending, excluding r0; with WB_BYPASS=1 a register being written this cycle is not pending and its operand is wb_data.
REQ-026 id_ready = !hazard && (!ex_valid || ex_ready); independent of if_valid.
REQ-027 Accept when if_valid && id_ready; bundle registered on that edge (latency 1 cycle).
REQ-028 If ex_valid && ex_ready && no accept: ex_valid->0 next edge. If ex_valid && !ex_ready: all ex_* held stable.
REQ-029 Operand values captured at accept; later register writes do not alter a held bundle.

Reset
REQ-030 rst while high: ex_valid=0, all ex_* outputs 0, pending mask 0, all registers 0; rst overrides accept and wb write in the same cycle.
REQ-031 Reset mid-stall or mid-backpressure discards the held bundle; id_ready=1 first cycle after rst deasserts.

Verification
REQ-032 wb r1=11, r2=2; ADD r3,r1,r2 accepted -> next cycle ex_valid=1, ex_I=0, op1=11, op2=2, ex_rd=3, ex_we=1.
REQ-033 ADDI r4,r0,0xFFFF -> op2=0xFFFFFFFF; ANDI r4,r0,0xFFFF -> op2=0x0000FFFF; LHI r5,0x1234 -> op1=0, op2=0x12340000.
REQ-034 ADD r3 issued, then SUB r6,r3,r1 presented -> id_ready=0 until wb_en rd=3 data=7; that cycle accepted (bypass) with op1=7.
REQ-035 ex_ready=0 for 3 cycles with bundle valid -> ex_* stable, id_ready=0; ex_ready=1 -> next instruction loaded the following edge.
REQ-036 wb r0=5, then ADD r1,r0,r0 -> op1=op2=0; op 0x3F -> ex_illegal=1, ex_we=0.
REQ-037 rst pulsed while stalled on a pending register -> ex_valid=0, mask cleared, id_ready=1 the first cycle after rst deasserts.
